// File: rtl/rand_share_arbiter.sv
// Shares one 16-bit LFSR among round-robin clients. Values are range-reduced by bounded rejection sampling.
// Defining RAND_STATS_EN builds saturating retry/fallback counters; otherwise the stat ports read 0.
module rand_share_arbiter #(
    parameter int          NUM_REQ   = 4,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_RETRY = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_lim,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   rnd_valid,
    output logic [15:0]            rnd_data,
    output logic                   busy,
    output logic [15:0]            stat_retries,
    output logic [15:0]            stat_fallbacks
);
    localparam int          PW       = $clog2(NUM_REQ);
    localparam int          RW       = $clog2(MAX_RETRY + 2);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;

    typedef enum logic [1:0] {IDLE, DRAW, GRANT} state_t;

    state_t               state_q;
    logic [15:0]          lfsr_q;
    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        win_q;
    logic [15:0]          lim_q;
    logic [15:0]          mask_q;
    logic [RW-1:0]        retry_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic                 valid_q;
    logic [15:0]          data_q;

    logic                 any_req;
    logic [PW-1:0]        win_d;
    logic [15:0]          lim_d;
    logic [15:0]          mask_d;
    logic [15:0]          lfsr_d;
    logic [15:0]          cand;
    logic                 hit;
    logic                 give_up;
    logic                 retry_ev;
    logic                 fall_ev;
    logic [PW-1:0]        ptr_d;

    assign lfsr_d = {lfsr_q[14:0],
                     lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // First requester at or after ptr, wrapping.
    always_comb begin
        int j;
        logic [PW-1:0] jj;
        j       = 0;
        jj      = '0;
        any_req = 1'b0;
        win_d   = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = PW'(j);
            if (!any_req && req[jj]) begin
                any_req = 1'b1;
                win_d   = jj;
            end
        end
    end

    assign lim_d = req_lim[{win_d, 4'b0000} +: 16];

    // Smallest all-ones mask covering lim-1, i.e. 2^ceil(log2(lim))-1.
    always_comb begin
        logic [15:0] m;
        m = lim_d - 16'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        mask_d = (lim_d == 16'd0) ? 16'd0 : m;
    end

    assign cand     = lfsr_q & mask_q;
    assign hit      = (lim_q == 16'd0) || (cand < lim_q);
    assign give_up  = (retry_q == RW'(MAX_RETRY));
    assign retry_ev = (state_q == DRAW) && !hit && !give_up;
    assign fall_ev  = (state_q == DRAW) && !hit && give_up;
    assign ptr_d    = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            ptr_q   <= '0;
            win_q   <= '0;
            lim_q   <= '0;
            mask_q  <= '0;
            retry_q <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (run || state_q == DRAW) lfsr_q <= lfsr_d;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        win_q   <= win_d;
                        lim_q   <= lim_d;
                        mask_q  <= mask_d;
                        retry_q <= '0;
                        state_q <= DRAW;
                    end
                end
                DRAW: begin
                    if (hit) begin
                        data_q  <= (lim_q == 16'd0) ? lfsr_q : cand;
                        gnt_q   <= NUM_REQ'(1) << win_q;
                        valid_q <= 1'b1;
                        state_q <= GRANT;
                    end else if (fall_ev) begin
                        // cand <= mask < 2*lim, so cand-lim < lim.
                        data_q  <= cand - lim_q;
                        gnt_q   <= NUM_REQ'(1) << win_q;
                        valid_q <= 1'b1;
                        state_q <= GRANT;
                    end else if (retry_ev) begin
                        retry_q <= retry_q + 1'b1;
                    end
                end
                GRANT: begin
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rnd_valid = valid_q;
    assign rnd_data  = data_q;
    assign busy      = (state_q != IDLE);

`ifdef RAND_STATS_EN
    logic [15:0] ret_q;
    logic [15:0] fb_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ret_q <= '0;
            fb_q  <= '0;
        end else begin
            if (retry_ev && ret_q != 16'hFFFF) ret_q <= ret_q + 16'd1;
            if (fall_ev && fb_q != 16'hFFFF) fb_q <= fb_q + 16'd1;
        end
    end

    assign stat_retries   = ret_q;
    assign stat_fallbacks = fb_q;
`else
    assign stat_retries   = 16'd0;
    assign stat_fallbacks = 16'd0;
`endif

endmodule
